// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage with optional skid entry, stall/flush and starvation counter.
// Flush outranks stall, which outranks the valid/ready handshakes.
module pipe_stage_reg #(
   parameter int                DATA_W     = 128,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter bit                SKID_EN    = 1'b1,
   parameter int                CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stall,
   input  logic              flush,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  bubble_cnt
);
   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
   state_t              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d, skid_q, skid_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                in_fire, out_fire;
   assign out_valid  = (state_q != EMPTY) & ~stall & ~flush;
   // With the skid entry, ready depends only on state, so it never sees out_ready.
   assign in_ready   = rst_n & ~stall & ~flush &
                       (SKID_EN ? (state_q != SKID) : ((state_q == EMPTY) | out_ready));
   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;
   assign out_data   = main_q;
   assign bubble_cnt = cnt_q;
   assign cnt_d      = cnt_clr ? '0 :
                       (~out_valid & out_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            EMPTY: if (in_fire) begin
               state_d = FULL;
               main_d  = in_data;
            end
            FULL: if (in_fire & out_fire) begin
               main_d = in_data;
            end else if (out_fire) begin
               state_d = EMPTY;
            end else if (in_fire) begin
               state_d = SKID;
               skid_d  = in_data;
            end
            SKID: if (out_fire) begin
               state_d = FULL;
               main_d  = skid_q;
            end
            default: state_d = EMPTY;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three configurations (skid, no skid, 4-bit counter) driven in lockstep
// and checked against a FIFO-count reference model, hand tables and corner sequences.
module tb_pipe_stage_reg;
   localparam logic [15:0] BUB = 16'hDEAD;
   logic        clk = 0, rst_n = 0;
   logic        in_valid = 0, out_ready = 0, stall = 0, flush = 0, cnt_clr = 0;
   logic [15:0] in_data = 0;
   logic        ov0, ov1, ov2, ir0, ir1, ir2;
   logic [15:0] od0, od1, od2;
   logic [31:0] bc0, bc1, b;
   logic [3:0]  bc2;
   int          total = 0, bad = 0;
   logic        a_ov[3], a_ir[3];
   logic [15:0] a_od[3];
   logic [31:0] a_bc[3];
   logic [15:0] ent[3][2];
   int          n[3];
   logic [15:0] hold[3];
   longint      cnt[3];
   bit          skid_en[3] = '{1'b1, 1'b0, 1'b1};
   longint      cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
   logic        e_ov[3], e_ir[3];
   logic [15:0] e_od[3];
   typedef struct {
      logic iv; logic [15:0] d; logic ordy, st, fl;
      logic ev, er; logic [15:0] ed;
   } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .BUBBLE_VAL(BUB), .SKID_EN(1'b1), .CNT_W(32)) u_skid (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .stall(stall), .flush(flush),
      .cnt_clr(cnt_clr), .bubble_cnt(bc0));
   pipe_stage_reg #(.DATA_W(16), .BUBBLE_VAL(BUB), .SKID_EN(1'b0), .CNT_W(32)) u_single (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .stall(stall), .flush(flush),
      .cnt_clr(cnt_clr), .bubble_cnt(bc1));
   pipe_stage_reg #(.DATA_W(16), .BUBBLE_VAL(BUB), .SKID_EN(1'b1), .CNT_W(4)) u_cnt4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .stall(stall), .flush(flush),
      .cnt_clr(cnt_clr), .bubble_cnt(bc2));

   always_comb begin
      a_ov = '{ov0, ov1, ov2};
      a_ir = '{ir0, ir1, ir2};
      a_od = '{od0, od1, od2};
      a_bc = '{bc0, bc1, {28'd0, bc2}};
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         n[i] = 0; hold[i] = BUB; cnt[i] = 0;
      end
   endtask

   task automatic expect_model();
      for (int i = 0; i < 3; i++) begin
         e_ov[i] = rst_n & (n[i] > 0) & ~stall & ~flush;
         e_ir[i] = rst_n & ~stall & ~flush & (skid_en[i] ? (n[i] < 2) : (n[i] == 0 || out_ready));
         e_od[i] = (n[i] > 0) ? ent[i][0] : hold[i];
      end
   endtask

   task automatic sample();
      @(negedge clk);
      expect_model();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d out_valid", i), a_ov[i], e_ov[i]);
         chk($sformatf("u%0d in_ready", i), a_ir[i], e_ir[i]);
         chk($sformatf("u%0d out_data", i), a_od[i], e_od[i]);
         chk($sformatf("u%0d bubble_cnt", i), a_bc[i], cnt[i]);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      expect_model();
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            cnt[i] = cnt_clr ? 0 : (!e_ov[i] && out_ready && cnt[i] < cmax[i]) ? cnt[i] + 1 : cnt[i];
            if (flush) begin
               n[i] = 0; hold[i] = BUB;
            end else begin
               if (e_ov[i] && out_ready) begin
                  hold[i] = ent[i][0]; ent[i][0] = ent[i][1]; n[i]--;
               end
               if (e_ir[i] && in_valid) begin
                  ent[i][n[i]] = in_data; n[i]++;
               end
            end
         end
      end
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic drv(input logic iv, input logic [15:0] d, input logic ordy,
                      input logic st, input logic fl, input logic clr);
      in_valid = iv; in_data = d; out_ready = ordy; stall = st; flush = fl; cnt_clr = clr;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 16'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BUB};
      tbl[1]  = '{1'b1, 16'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1};
      tbl[2]  = '{1'b1, 16'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2};
      tbl[3]  = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3};
      tbl[4]  = '{1'b1, 16'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3};
      tbl[5]  = '{1'b1, 16'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA};
      tbl[6]  = '{1'b1, 16'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA};
      tbl[7]  = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA};
      tbl[8]  = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hB};
      tbl[9]  = '{1'b1, 16'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hB};
      tbl[10] = '{1'b1, 16'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hB};
      tbl[11] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BUB};
      model_reset();
      repeat (2) cycle();
      rst_n = 1;
      foreach (tbl[k]) begin
         drv(tbl[k].iv, tbl[k].d, tbl[k].ordy, tbl[k].st, tbl[k].fl, 1'b0);
         sample();
         chk($sformatf("tbl%0d valid", k), ov0, tbl[k].ev);
         chk($sformatf("tbl%0d ready", k), ir0, tbl[k].er);
         chk($sformatf("tbl%0d data", k), od0, tbl[k].ed);
         advance();
      end
      // stall while holding 0x55
      drv(1'b1, 16'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      b = bc0;
      drv(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         sample();
         chk("stall valid", ov0, 0);
         chk("stall ready", ir0, 0);
         advance();
      end
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      sample();
      chk("stall cnt delta", bc0 - b, 3);
      chk("release valid", ov0, 1);
      chk("release data", od0, 16'h55);
      advance();
      // fill skid with A/B, then flush together with stall
      drv(1'b1, 16'hA, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      drv(1'b1, 16'hB, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      drv(1'b1, 16'hC, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      chk("skid ready", ir0, 0);
      chk("skid data", od0, 16'hA);
      chk("single ready", ir1, 0);
      chk("single data", od1, 16'hA);
      advance();
      drv(1'b1, 16'hC, 1'b1, 1'b1, 1'b1, 1'b0);
      sample();
      chk("flush valid", ov0, 0);
      chk("flush ready", ir0, 0);
      advance();
      drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      chk("post-flush valid", ov0, 0);
      chk("post-flush data", od0, BUB);
      chk("post-flush ready", ir0, 1);
      advance();
      // asynchronous reset between edges while FULL
      drv(1'b1, 16'h77, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst_n = 0;
      #1;
      chk("async rst valid", ov0, 0);
      chk("async rst ready", ir0, 0);
      chk("async rst cnt", bc0, 0);
      chk("async rst data", od0, BUB);
      model_reset();
      repeat (2) cycle();
      #2 rst_n = 1;
      drv(1'b1, 16'h88, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      sample();
      chk("after rst valid", ov0, 1);
      chk("after rst data", od0, 16'h88);
      advance();
      // starve the 4-bit counter into saturation, then clear on a starved cycle
      repeat (20) cycle();
      sample();
      chk("cnt4 saturated", bc2, 15);
      advance();
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      sample();
      chk("cnt4 cleared", bc2, 0);
      advance();
      repeat (400) begin
         if (!(in_valid && !ir0)) in_data = 16'($urandom);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         stall     = ($urandom_range(7) == 0);
         flush     = ($urandom_range(15) == 0);
         cnt_clr   = ($urandom_range(31) == 0);
         cycle();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
